// File: rtl/noc_packet_buffer.sv
// Packet buffer between the packet generator and the destination handshake.
// Stores up to DEPTH packets in order and returns a one-cycle ack per accepted packet.
module noc_packet_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ack,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ack;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;

    // Explicit wrap keeps non-power-of-two depths gap-free.
    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_wr    = in_valid && in_ready;
    assign w_rd    = !w_empty && out_ready && !flush;

    assign in_ready  = !w_full && !flush;
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign ack       = r_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ack    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ack    <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= f_next(r_wr_ptr);
            if (w_rd)
                r_rd_ptr <= f_next(r_rd_ptr);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_ack <= w_wr;
        end
    end

    // Storage needs no reset: out_data is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= in_data;
    end
endmodule

// File: tb/tb_noc_packet_buffer.sv
// Self-checking bench for noc_packet_buffer: DEPTH=8 and DEPTH=6 instances share stimulus,
// each tracked by its own reference queue; a vector table drives the main sequences.
module tb_noc_packet_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready8, ack8, out_valid8, full8, empty8;
    logic [31:0] out_data8;
    logic [3:0]  count8;
    logic        in_ready6, ack6, out_valid6, full6, empty6;
    logic [31:0] out_data6;
    logic [3:0]  count6;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [31:0] q8[$];
    logic [31:0] q6[$];
    logic        a8, a6;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        int unsigned cnt;
        logic        ack;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    noc_packet_buffer #(.DATA_W(32), .DEPTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready8),
        .ack(ack8), .out_valid(out_valid8), .out_data(out_data8),
        .out_ready(out_ready), .count(count8), .full(full8), .empty(empty8)
    );

    noc_packet_buffer #(.DATA_W(32), .DEPTH(6), .CNT_W(4)) dut6 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready6),
        .ack(ack6), .out_valid(out_valid6), .out_data(out_data6),
        .out_ready(out_ready), .count(count6), .full(full6), .empty(empty6)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Compare both DUTs against their queues, then advance one clock and update the models.
    task automatic step();
        logic w8, r8, w6, r6;
        #1;
        check("d8_in_ready",  in_ready8,  !flush && q8.size() < 8);
        check("d8_out_valid", out_valid8, q8.size() != 0);
        check("d8_out_data",  out_data8,  (q8.size() != 0) ? q8[0] : 32'h0);
        check("d8_count",     count8,     q8.size());
        check("d8_full",      full8,      q8.size() == 8);
        check("d8_empty",     empty8,     q8.size() == 0);
        check("d8_ack",       ack8,       a8);
        check("d6_in_ready",  in_ready6,  !flush && q6.size() < 6);
        check("d6_out_valid", out_valid6, q6.size() != 0);
        check("d6_out_data",  out_data6,  (q6.size() != 0) ? q6[0] : 32'h0);
        check("d6_count",     count6,     q6.size());
        check("d6_full",      full6,      q6.size() == 6);
        check("d6_empty",     empty6,     q6.size() == 0);
        check("d6_ack",       ack6,       a6);
        w8 = in_valid && !flush && q8.size() < 8;
        r8 = out_ready && !flush && q8.size() != 0;
        w6 = in_valid && !flush && q6.size() < 6;
        r6 = out_ready && !flush && q6.size() != 0;
        @(posedge clk);
        if (flush) begin
            q8.delete(); q6.delete(); a8 = 1'b0; a6 = 1'b0;
        end else begin
            if (r8) void'(q8.pop_front());
            if (w8) q8.push_back(in_data);
            if (r6) void'(q6.pop_front());
            if (w6) q6.push_back(in_data);
            a8 = w8; a6 = w6;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] id, input logic ordy);
        flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        q8.delete(); q6.delete(); a8 = 1'b0; a6 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_count", count8, 0);
        check("rst_empty", empty8, 1);
        check("rst_in_ready", in_ready8, 1);
    endtask

    task automatic add(input logic fl, input logic iv, input logic [31:0] id,
                       input logic ordy, input int unsigned cnt, input logic ak);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy; v.cnt = cnt; v.ack = ak;
        tbl.push_back(v);
    endtask

    initial begin
        // Fill to full, overflow attempts, drain, then simultaneous read/write at count 3.
        for (int i = 0; i < 8; i++) add(0, 1, 32'hA0 + i, 0, i + 1, 1);
        for (int i = 0; i < 3; i++) add(0, 1, 32'hFF, 0, 8, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 32'h0, 1, 7 - i, 0);
        add(0, 0, 32'h0, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 32'hC0 + i, 0, i + 1, 1);
        for (int i = 0; i < 5; i++) add(0, 1, 32'hC3 + i, 1, 3, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 32'h0, 1, 2 - i, 0);

        @(negedge clk);
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ordy);
            check($sformatf("tbl_cnt[%0d]", i), count8, tbl[i].cnt);
            check($sformatf("tbl_ack[%0d]", i), ack8, tbl[i].ack);
        end

        // Pointer wrap on both depths.
        do_reset();
        for (int i = 0; i < 6; i++) drive(0, 1, 32'hD0 + i, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 32'h0, 1);
        for (int i = 0; i < 8; i++) drive(0, 1, 32'hB0 + i, 0);
        check("wrap_full8", count8, 8);
        for (int i = 0; i < 8; i++) drive(0, 0, 32'h0, 1);
        drive(0, 0, 32'h0, 0);
        check("wrap_empty8", empty8, 1);

        // Flush at count 5 with a write pending.
        do_reset();
        for (int i = 0; i < 5; i++) drive(0, 1, 32'hE0 + i, 0);
        drive(1, 1, 32'hEE, 1);
        check("flush_count", count8, 0);
        check("flush_no_ack", ack8, 0);
        drive(0, 0, 32'h0, 0);

        // Asynchronous reset mid-cycle with count 4 and an ack in flight.
        for (int i = 0; i < 4; i++) drive(0, 1, 32'hF0 + i, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("arst_count", count8, 0);
        check("arst_valid", out_valid8, 0);
        check("arst_data", out_data8, 0);
        check("arst_empty", empty8, 1);
        check("arst_full", full8, 0);
        check("arst_in_ready", in_ready8, 1);
        check("arst_ack", ack8, 0);
        q8.delete(); q6.delete(); a8 = 1'b0; a6 = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, 32'h5A, 0);
        check("post_rst_valid", out_valid8, 1);
        check("post_rst_data", out_data8, 32'h5A);
        drive(0, 0, 32'h0, 1);
        drive(0, 0, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
